// File: rtl/ram_port_arbiter.sv
// Two-client arbiter in front of one simple dual-port RAM (1 write port, 1 registered read port).
// Independent round-robin per port; same-cycle read-after-write to one address stalls the read.
module ram_port_arbiter #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_wr_valid,
    output logic              c0_wr_ready,
    input  logic [ADDR_W-1:0] c0_wr_addr,
    input  logic [WIDTH-1:0]  c0_wr_data,
    input  logic              c0_rd_valid,
    output logic              c0_rd_ready,
    input  logic [ADDR_W-1:0] c0_rd_addr,
    output logic              c0_rvalid,
    output logic [WIDTH-1:0]  c0_rdata,
    input  logic              c1_wr_valid,
    output logic              c1_wr_ready,
    input  logic [ADDR_W-1:0] c1_wr_addr,
    input  logic [WIDTH-1:0]  c1_wr_data,
    input  logic              c1_rd_valid,
    output logic              c1_rd_ready,
    input  logic [ADDR_W-1:0] c1_rd_addr,
    output logic              c1_rvalid,
    output logic [WIDTH-1:0]  c1_rdata,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [WIDTH-1:0]  ram_data,
    output logic [ADDR_W-1:0] ram_rdaddress,
    input  logic [WIDTH-1:0]  ram_q
);
    localparam int NCL = 2;

    logic [NCL-1:0]             wr_req, rd_req, wr_gnt, rd_gnt;
    logic [NCL-1:0][ADDR_W-1:0] wr_addr, rd_addr;
    logic [NCL-1:0][WIDTH-1:0]  wr_data;
    logic                       wr_prio, rd_prio;
    logic                       wr_sel, rd_sel, wr_any, rd_any, hazard;
    logic [NCL-1:0]             rvld_q;

    // Winner index; with no request it falls back to client 0 so idle muxes are stable.
    function automatic logic rr_pick(input logic [NCL-1:0] req, input logic prio);
        return (req == 2'b11) ? prio : req[1];
    endfunction

    assign wr_req  = {c1_wr_valid, c0_wr_valid} & {NCL{rst_n}};
    assign rd_req  = {c1_rd_valid, c0_rd_valid} & {NCL{rst_n}};
    assign wr_addr = {c1_wr_addr, c0_wr_addr};
    assign wr_data = {c1_wr_data, c0_wr_data};
    assign rd_addr = {c1_rd_addr, c0_rd_addr};

    always_comb begin
        wr_gnt = '0;
        rd_gnt = '0;
        wr_any = |wr_req;
        rd_any = |rd_req;
        wr_sel = rr_pick(wr_req, wr_prio);
        rd_sel = rr_pick(rd_req, rd_prio);
        // The read waits one cycle so it observes the word being written now.
        hazard = wr_any && rd_any && (rd_addr[rd_sel] == wr_addr[wr_sel]);
        if (wr_any)
            wr_gnt[wr_sel] = 1'b1;
        if (rd_any && !hazard)
            rd_gnt[rd_sel] = 1'b1;
    end

    assign c0_wr_ready   = wr_gnt[0];
    assign c1_wr_ready   = wr_gnt[1];
    assign c0_rd_ready   = rd_gnt[0];
    assign c1_rd_ready   = rd_gnt[1];
    assign ram_wren      = wr_any;
    assign ram_wraddress = wr_addr[wr_sel];
    assign ram_data      = wr_data[wr_sel];
    assign ram_rdaddress = rd_addr[rd_sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_prio <= 1'b0;
            rd_prio <= 1'b0;
            rvld_q  <= '0;
        end else begin
            if (wr_any)
                wr_prio <= ~wr_sel;
            if (|rd_gnt)
                rd_prio <= ~rd_sel;
            rvld_q <= rd_gnt;
        end
    end

    assign c0_rvalid = rvld_q[0];
    assign c1_rvalid = rvld_q[1];
    assign c0_rdata  = ram_q;
    assign c1_rdata  = ram_q;
endmodule
